// File: rtl/fft4_pkg.sv
// fft4_pkg: state encoding, frame size and width helpers shared by the
// 4-point FFT sequencer and its bin multiplexer.
package fft4_pkg;
   localparam int N_PTS = 4;
   typedef enum logic [2:0] {ST_LOAD, ST_S1A, ST_S1B, ST_S2, ST_OUT} state_t;
   function automatic int bw_of(input int w);
      return w + 1;
   endfunction
   function automatic int ow_of(input int w);
      return w + 2;
   endfunction
endpackage

// File: rtl/fft4_bin_mux.sv
// fft4_bin_mux: forms (re, im) of bin k from the stage results.
// FFT4_SCALE_EN: when defined, both parts are floor-divided by 4.
module fft4_bin_mux
   import fft4_pkg::*;
#(
   parameter  int W  = 8,
   localparam int BW = bw_of(W),
   localparam int OW = ow_of(W)
) (
   input  logic [1:0]           i_idx,
   input  logic signed [OW-1:0] i_x0r,
   input  logic signed [OW-1:0] i_x2r,
   input  logic signed [BW-1:0] i_a1,
   input  logic signed [BW-1:0] i_b1,
   output logic signed [OW-1:0] o_re,
   output logic signed [OW-1:0] o_im
);
   logic signed [OW-1:0] w_re, w_im, w_b1;
   assign w_b1 = OW'(i_b1);
   assign w_re = i_idx == 2'd0 ? i_x0r : i_idx == 2'd2 ? i_x2r : OW'(i_a1);
   // negation at full output width, so -(-2^W) cannot wrap
   assign w_im = i_idx == 2'd1 ? -w_b1 : i_idx == 2'd3 ? w_b1 : '0;
`ifdef FFT4_SCALE_EN
   assign o_re = w_re >>> 2;
   assign o_im = w_im >>> 2;
`else
   assign o_re = w_re;
   assign o_im = w_im;
`endif
endmodule

// File: rtl/fft4_seq_ctrl.sv
// fft4_seq_ctrl: sequences a 4-point radix-2 DIT FFT over one external butterfly.
// FFT4_SCALE_EN: when defined, output bins are scaled by 1/4.
module fft4_seq_ctrl
   import fft4_pkg::*;
#(
   parameter  int W  = 8,
   localparam int BW = bw_of(W),
   localparam int OW = ow_of(W)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [W-1:0]  in_data,
   output logic signed [BW-1:0] bf_a,
   output logic signed [BW-1:0] bf_b,
   input  logic signed [BW:0]   bf_c,
   input  logic signed [BW:0]   bf_d,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [OW-1:0] out_re,
   output logic signed [OW-1:0] out_im,
   output logic [1:0]           out_idx,
   output logic                 out_last,
   output logic                 busy
);
   state_t r_state, w_next;
   logic [1:0] r_cnt, r_idx, w_sel;
   logic signed [W-1:0] r_x [N_PTS];
   logic signed [BW-1:0] r_a0, r_a1, r_b0, r_b1;
   logic signed [OW-1:0] r_x0r, r_x2r, r_re, r_im, w_re, w_im;
   logic r_oval, w_in_fire, w_out_fire;

   assign in_ready   = r_state == ST_LOAD;
   assign busy       = !in_ready;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_oval && out_ready;
   assign out_valid  = r_oval;
   assign out_idx    = r_idx;
   assign out_last   = r_oval && r_idx == 2'd3;
   assign out_re     = r_re;
   assign out_im     = r_im;
   // first OUT cycle preloads bin 0; afterwards each transfer preloads the next bin
   assign w_sel      = r_oval ? r_idx + 2'd1 : r_idx;

   fft4_bin_mux #(.W(W)) u_mux (
      .i_idx (w_sel),
      .i_x0r (r_x0r),
      .i_x2r (r_x2r),
      .i_a1  (r_a1),
      .i_b1  (r_b1),
      .o_re  (w_re),
      .o_im  (w_im)
   );

   always_comb begin
      w_next = r_state;
      bf_a   = '0;
      bf_b   = '0;
      case (r_state)
         ST_LOAD: w_next = w_in_fire && r_cnt == 2'(N_PTS - 1) ? ST_S1A : ST_LOAD;
         ST_S1A: begin
            w_next = ST_S1B;
            bf_a   = BW'(r_x[0]);
            bf_b   = BW'(r_x[2]);
         end
         ST_S1B: begin
            w_next = ST_S2;
            bf_a   = BW'(r_x[1]);
            bf_b   = BW'(r_x[3]);
         end
         ST_S2: begin
            w_next = ST_OUT;
            bf_a   = r_a0;
            bf_b   = r_b0;
         end
         ST_OUT:  w_next = w_out_fire && r_idx == 2'd3 ? ST_LOAD : ST_OUT;
         default: w_next = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_LOAD;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_oval  <= 1'b0;
         r_x     <= '{default: '0};
         r_a0    <= '0;
         r_a1    <= '0;
         r_b0    <= '0;
         r_b1    <= '0;
         r_x0r   <= '0;
         r_x2r   <= '0;
         r_re    <= '0;
         r_im    <= '0;
      end else begin
         r_state <= w_next;
         if (w_in_fire) begin
            r_x[r_cnt] <= in_data;
            r_cnt      <= r_cnt + 2'd1;
         end
         if (r_state == ST_S1A) begin
            r_a0 <= bf_c[BW-1:0];
            r_a1 <= bf_d[BW-1:0];
         end
         if (r_state == ST_S1B) begin
            r_b0 <= bf_c[BW-1:0];
            r_b1 <= bf_d[BW-1:0];
         end
         if (r_state == ST_S2) begin
            r_x0r <= bf_c;
            r_x2r <= bf_d;
         end
         if (r_state == ST_OUT && (!r_oval || out_ready)) begin
            r_oval <= !(r_oval && r_idx == 2'd3);
            r_idx  <= w_sel;
            r_re   <= w_re;
            r_im   <= w_im;
         end
      end
   end
endmodule
